down_counter: RTL

- Loadable down-counter with a start/busy/done handshake.
- Counterpart to the team's up-counter: counts a loaded value down to zero, then signals completion.
- Used by controllers as a countdown/iteration timer (e.g. "run N steps, then proceed").
- Holds a datapath register and a 3-state FSM.

---
 rtl/down_counter_pkg.sv | 10 +
 rtl/down_counter.sv | 104 ++++++++++
 2 files changed

// File: rtl/down_counter_pkg.sv
// rtl/down_counter_pkg.sv - shared state encoding for the loadable down-counter
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dc_state_t;

endpackage

// File: rtl/down_counter.sv
// rtl/down_counter.sv - loadable down-counter with start/busy/done handshake
// Optional periodic auto-reload mode: DOWN_COUNTER_AUTO_RELOAD_EN
module down_counter
  import down_counter_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            start,
  input  logic            pause,
  input  logic [size-1:0] dataIn,
  output logic [size-1:0] dataOut,
  output logic            busy,
  output logic            done,
  output logic            zero
);

  localparam logic [size-1:0] count_one = 1;

  dc_state_t       state, state_nxt;
  logic [size-1:0] count, count_nxt;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [size-1:0] reload, reload_nxt;
`endif

  always_comb begin
    state_nxt = state;
    count_nxt = count;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_nxt = reload;
`endif
    if (clear) begin
      state_nxt = IDLE;
      count_nxt = '0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_nxt = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            count_nxt = dataIn;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_nxt = dataIn;
`endif
          end else if (start) begin
            state_nxt = (count == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // Terminate on 1->0 (or a stray 0) so the count never wraps.
          if (!pause) begin
            if (count <= count_one) begin
              count_nxt = '0;
              state_nxt = DONE;
            end else begin
              count_nxt = count - count_one;
            end
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          if (reload != '0) begin
            count_nxt = reload;
            state_nxt = RUN;
          end else begin
            state_nxt = IDLE;
          end
`else
          state_nxt = IDLE;
`endif
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) reload <= '0;
    else      reload <= reload_nxt;
  end
`endif

  assign dataOut = count;
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign zero    = (count == '0);

endmodule
